// File: rtl/frame_pkg.sv
// Shared definitions for the frame register file and its readers.
package frame_pkg;

    localparam int FRAME_W      = 32;
    localparam int N_FRAMES     = 16;
    localparam int SMALL_FRAMES = 4;

    typedef logic [31:0] frame_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } frame_state_t;

    // Index of the final word of a burst: big mode streams every frame.
    function automatic logic [3:0] last_index(input logic big);
        return big ? 4'(N_FRAMES - 1) : 4'(SMALL_FRAMES - 1);
    endfunction

endpackage

// File: rtl/frame_reader.sv
// Snapshots the sixteen frame words on load and streams them out
// over valid/ready, either all sixteen or only the first four.
module frame_reader #(
    parameter int FRAME_W      = frame_pkg::FRAME_W,
    parameter int N_FRAMES     = frame_pkg::N_FRAMES,
    parameter int SMALL_FRAMES = frame_pkg::SMALL_FRAMES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Small_or_Big,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame_0_in,
    input  logic [FRAME_W-1:0] frame_1_in,
    input  logic [FRAME_W-1:0] frame_2_in,
    input  logic [FRAME_W-1:0] frame_3_in,
    input  logic [FRAME_W-1:0] frame_4_in,
    input  logic [FRAME_W-1:0] frame_5_in,
    input  logic [FRAME_W-1:0] frame_6_in,
    input  logic [FRAME_W-1:0] frame_7_in,
    input  logic [FRAME_W-1:0] frame_8_in,
    input  logic [FRAME_W-1:0] frame_9_in,
    input  logic [FRAME_W-1:0] frame_10_in,
    input  logic [FRAME_W-1:0] frame_11_in,
    input  logic [FRAME_W-1:0] frame_12_in,
    input  logic [FRAME_W-1:0] frame_13_in,
    input  logic [FRAME_W-1:0] frame_14_in,
    input  logic [FRAME_W-1:0] frame_15_in,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [FRAME_W-1:0] out_data,
    output logic [3:0]         out_index,
    output logic               out_last,
    output logic               busy,
    output logic               done
);
    import frame_pkg::*;

    logic [FRAME_W-1:0] frame_in [N_FRAMES];
    logic [FRAME_W-1:0] buf_reg  [N_FRAMES];

    frame_state_t       state_reg;
    logic [3:0]         idx_reg;
    logic [3:0]         idx_next;
    logic               mode_reg;
    logic               valid_reg;
    logic [FRAME_W-1:0] data_reg;
    logic               last_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               capture;

    assign frame_in[0]  = frame_0_in;
    assign frame_in[1]  = frame_1_in;
    assign frame_in[2]  = frame_2_in;
    assign frame_in[3]  = frame_3_in;
    assign frame_in[4]  = frame_4_in;
    assign frame_in[5]  = frame_5_in;
    assign frame_in[6]  = frame_6_in;
    assign frame_in[7]  = frame_7_in;
    assign frame_in[8]  = frame_8_in;
    assign frame_in[9]  = frame_9_in;
    assign frame_in[10] = frame_10_in;
    assign frame_in[11] = frame_11_in;
    assign frame_in[12] = frame_12_in;
    assign frame_in[13] = frame_13_in;
    assign frame_in[14] = frame_14_in;
    assign frame_in[15] = frame_15_in;

    assign capture  = (state_reg == IDLE) && load;
    assign idx_next = idx_reg + 4'd1;

    // Snapshot is taken only from IDLE, so later input changes cannot
    // disturb a burst in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_FRAMES; i++) begin
                buf_reg[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < N_FRAMES; i++) begin
                buf_reg[i] <= frame_in[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            mode_reg  <= 1'b0;
            valid_reg <= 1'b0;
            data_reg  <= '0;
            last_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    if (load) begin
                        state_reg <= STREAM;
                        mode_reg  <= Small_or_Big;
                        idx_reg   <= '0;
                        valid_reg <= 1'b1;
                        data_reg  <= frame_0_in;
                        last_reg  <= (last_index(Small_or_Big) == 4'd0);
                        busy_reg  <= 1'b1;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (last_reg) begin
                            state_reg <= DONE;
                            idx_reg   <= '0;
                            valid_reg <= 1'b0;
                            data_reg  <= '0;
                            last_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            // Preload the next word so outputs stay registered.
                            idx_reg  <= idx_next;
                            data_reg <= buf_reg[idx_next];
                            last_reg <= (idx_next == last_index(mode_reg));
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    idx_reg   <= '0;
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                    last_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_index = idx_reg;
    assign out_last  = last_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader: table-driven bursts plus hand-written
// sequences for ignored load, mid-burst reset and reset-with-load.
module tb_frame_reader;

    typedef struct {
        logic        rdy;
        logic        v;
        logic [31:0] d;
        logic [3:0]  i;
        logic        l;
        logic        b;
        logic        dn;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Small_or_Big = 1'b0;
    logic        load = 1'b0;
    logic [31:0] frame_in [16];
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    frame_reader dut (
        .clk(clk), .rst(rst), .Small_or_Big(Small_or_Big), .load(load),
        .frame_0_in(frame_in[0]),   .frame_1_in(frame_in[1]),
        .frame_2_in(frame_in[2]),   .frame_3_in(frame_in[3]),
        .frame_4_in(frame_in[4]),   .frame_5_in(frame_in[5]),
        .frame_6_in(frame_in[6]),   .frame_7_in(frame_in[7]),
        .frame_8_in(frame_in[8]),   .frame_9_in(frame_in[9]),
        .frame_10_in(frame_in[10]), .frame_11_in(frame_in[11]),
        .frame_12_in(frame_in[12]), .frame_13_in(frame_in[13]),
        .frame_14_in(frame_in[14]), .frame_15_in(frame_in[15]),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic v, input logic [31:0] d,
                         input logic [3:0] i, input logic l, input logic b, input logic dn);
        checks++;
        if (out_valid !== v || out_data !== d || out_index !== i ||
            out_last !== l || busy !== b || done !== dn) begin
            errors++;
            $display("FAIL %s: got v=%b d=%h i=%0d l=%b b=%b dn=%b, want v=%b d=%h i=%0d l=%b b=%b dn=%b",
                     name, out_valid, out_data, out_index, out_last, busy, done,
                     v, d, i, l, b, dn);
        end else begin
            $display("ok   %s: v=%b d=%h i=%0d l=%b b=%b dn=%b",
                     name, out_valid, out_data, out_index, out_last, busy, done);
        end
    endtask

    task automatic set_frames(input logic [31:0] base, input bit all_ones);
        for (int k = 0; k < 16; k++) begin
            frame_in[k] = all_ones ? 32'hFFFF_FFFF : base + 32'(k);
        end
    endtask

    task automatic do_load(input logic [31:0] base, input logic big);
        set_frames(base, 1'b0);
        Small_or_Big = big;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    // Expected stream: a stalled word simply repeats; ready follows 1,0,0,1.
    task automatic add_burst(input logic [31:0] base, input int nwords, input bit backpress);
        bit pat [4];
        int k;
        vec_t e;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        k = 0;
        for (int w = 0; w < nwords; w++) begin
            do begin
                e.rdy = backpress ? pat[k % 4] : 1'b1;
                e.v   = 1'b1;
                e.d   = base + 32'(w);
                e.i   = 4'(w);
                e.l   = (w == nwords - 1);
                e.b   = 1'b1;
                e.dn  = 1'b0;
                vecs.push_back(e);
                k++;
            end while (!e.rdy);
        end
        e.rdy = 1'b1; e.v = 1'b0; e.d = '0; e.i = '0; e.l = 1'b0; e.b = 1'b1; e.dn = 1'b1;
        vecs.push_back(e);
        e.b = 1'b0; e.dn = 1'b0;
        vecs.push_back(e);
    endtask

    task automatic run_vecs(input string name);
        for (int n = 0; n < vecs.size(); n++) begin
            check($sformatf("%s[%0d]", name, n), vecs[n].v, vecs[n].d, vecs[n].i,
                  vecs[n].l, vecs[n].b, vecs[n].dn);
            out_ready = vecs[n].rdy;
            tick();
        end
        vecs.delete();
    endtask

    initial begin
        set_frames(32'h0, 1'b0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("reset", 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Big mode, ready held high
        out_ready = 1'b1;
        do_load(32'h1000_0000, 1'b1);
        add_burst(32'h1000_0000, 16, 1'b0);
        run_vecs("big");

        // Small mode
        do_load(32'h1000_0000, 1'b0);
        add_burst(32'h1000_0000, 4, 1'b0);
        run_vecs("small");

        // Backpressure on a big burst
        out_ready = 1'b1;
        do_load(32'h4000_0100, 1'b1);
        add_burst(32'h4000_0100, 16, 1'b1);
        run_vecs("bp");

        // Load and input changes at word 5 are ignored
        out_ready = 1'b1;
        do_load(32'h1000_0000, 1'b1);
        for (int w = 0; w < 16; w++) begin
            check($sformatf("ign[%0d]", w), 1'b1, 32'h1000_0000 + 32'(w), 4'(w),
                  (w == 15), 1'b1, 1'b0);
            if (w == 5) begin
                set_frames(32'h0, 1'b1);
                Small_or_Big = 1'b0;
                load = 1'b1;
            end
            tick();
            load = 1'b0;
        end
        check("ign_done", 1'b0, 32'h0, 4'd0, 1'b0, 1'b1, 1'b1);
        tick();
        check("ign_idle", 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);

        // Reset at word 7 aborts without done
        do_load(32'h2000_0000, 1'b1);
        for (int w = 0; w < 8; w++) begin
            check($sformatf("rst_run[%0d]", w), 1'b1, 32'h2000_0000 + 32'(w), 4'(w),
                  1'b0, 1'b1, 1'b0);
            if (w == 7) rst = 1'b1;
            tick();
        end
        rst = 1'b0;
        check("rst_abort", 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("rst_nodone", 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        do_load(32'h3000_0000, 1'b0);
        add_burst(32'h3000_0000, 4, 1'b0);
        run_vecs("restart");

        // Reset and load together: reset wins
        set_frames(32'h5000_0000, 1'b0);
        Small_or_Big = 1'b1;
        rst = 1'b1;
        load = 1'b1;
        tick();
        rst = 1'b0;
        load = 1'b0;
        check("rst_load", 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick();
        check("rst_load_idle", 1'b0, 32'h0, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
